// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges stage stall requests, accepts each taken EX branch once,
// and issues the PC redirect (deferred while PC is frozen). Optional perf counters: PIPE_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_mem_i,
  input  logic              ex_b_flag_i,
  input  logic [ADDR_W-1:0] ex_b_target_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              pc_redirect_o,
  output logic [ADDR_W-1:0] pc_redirect_addr_o,
  output logic              redirect_pend_o,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_count_o
);

  // state[0] = br_lock, state[1] = pend
  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_LOCKED = 2'b01;
  localparam logic [1:0] ST_PEND   = 2'b11;

  logic [1:0]        state, state_d;
  logic [ADDR_W-1:0] pend_addr;
  logic              br_lock, pend, accept;

  assign br_lock = state[0];
  assign pend    = state[1];

  always_comb begin
    stall_o = 6'b000000;
    if (stallreq_mem_i)     stall_o = 6'b011111;
    else if (stallreq_ex_i) stall_o = 6'b001111;
    else if (stallreq_id_i) stall_o = 6'b000111;
    else if (stallreq_if_i) stall_o = 6'b000011;
  end

  // Gated by rst so a branch seen during reset never leaks a flush or redirect.
  assign accept = rst & ex_b_flag_i & ~br_lock;

  always_comb begin
    state_d            = state;
    flush_o            = accept;
    pc_redirect_o      = 1'b0;
    pc_redirect_addr_o = '0;
    case (state)
      ST_RUN: begin
        if (accept) begin
          if (stall_o[0]) begin
            state_d = ST_PEND;
          end else begin
            pc_redirect_o      = 1'b1;
            pc_redirect_addr_o = ex_b_target_i;
            state_d            = stall_o[3] ? ST_LOCKED : ST_RUN;
          end
        end
      end
      ST_LOCKED: begin
        if (!stall_o[3]) state_d = ST_RUN;
      end
      ST_PEND: begin
        // Frozen stages only hold bubbles here, so the redirect needs no flush.
        // br_lock survives this edge because pend was still set.
        if (!stall_o[0]) begin
          pc_redirect_o      = 1'b1;
          pc_redirect_addr_o = pend_addr;
          state_d            = ST_LOCKED;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      pend_addr <= '0;
    end else begin
      state <= state_d;
      if (accept && stall_o[0]) pend_addr <= ex_b_target_i;
    end
  end

  assign redirect_pend_o = pend;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall_o != 6'b000000) && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (accept && !(&flush_cnt))                 flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt;
  assign flush_count_o  = flush_cnt;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a reference model pushes expected outputs to a scoreboard
// each cycle; they are popped and compared against the DUT on the falling edge.
module tb_pipe_ctrl;
  localparam int AW = 32;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_if, req_id, req_ex, req_mem, b_flag;
  logic [AW-1:0] b_tgt;
  logic [5:0]    stall;
  logic          flush, red, rpend;
  logic [AW-1:0] raddr;
  logic [PW-1:0] scyc, fcnt;

  pipe_ctrl #(.ADDR_W(AW), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(req_if), .stallreq_id_i(req_id),
    .stallreq_ex_i(req_ex), .stallreq_mem_i(req_mem),
    .ex_b_flag_i(b_flag), .ex_b_target_i(b_tgt),
    .stall_o(stall), .flush_o(flush), .pc_redirect_o(red),
    .pc_redirect_addr_o(raddr), .redirect_pend_o(rpend),
    .stall_cycles_o(scyc), .flush_count_o(fcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    stall;
    logic          flush;
    logic          red;
    logic [AW-1:0] addr;
    logic          pend;
    logic [PW-1:0] sc;
    logic [PW-1:0] fc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_red    = 0;
  int n_flush  = 0;

  // reference model state
  logic          m_lock, m_pend;
  logic [AW-1:0] m_paddr;
  logic [PW-1:0] m_sc, m_fc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_pend = 1'b0; m_paddr = '0; m_sc = '0; m_fc = '0;
  endtask

  // Inputs are set by the caller just after a rising edge; this checks and advances one cycle.
  task automatic cycle();
    exp_t e, o;
    logic acc;
    @(negedge clk);
    if (req_mem)     e.stall = 6'b011111;
    else if (req_ex) e.stall = 6'b001111;
    else if (req_id) e.stall = 6'b000111;
    else if (req_if) e.stall = 6'b000011;
    else             e.stall = 6'b000000;
    acc     = rst && b_flag && !m_lock;
    e.flush = acc;
    e.red   = rst && !e.stall[0] && (acc || m_pend);
    e.addr  = !e.red ? '0 : (m_pend ? m_paddr : b_tgt);
    e.pend  = m_pend;
`ifdef PIPE_PERF_CNT_EN
    e.sc = m_sc; e.fc = m_fc;
`else
    e.sc = '0; e.fc = '0;
`endif
    sb.push_back(e);

    o = sb.pop_front();
    chk("stall_o", 64'(stall), 64'(o.stall));
    chk("flush_o", 64'(flush), 64'(o.flush));
    chk("pc_redirect_o", 64'(red), 64'(o.red));
    chk("pc_redirect_addr_o", 64'(raddr), 64'(o.addr));
    chk("redirect_pend_o", 64'(rpend), 64'(o.pend));
    chk("stall_cycles_o", 64'(scyc), 64'(o.sc));
    chk("flush_count_o", 64'(fcnt), 64'(o.fc));
    n_red   += int'(red);
    n_flush += int'(flush);

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (e.stall != 6'b0 && m_sc != '1) m_sc = m_sc + 1'b1;
      if (acc && m_fc != '1)             m_fc = m_fc + 1'b1;
      if (acc) begin
        m_lock = 1'b1;
        if (e.stall[0]) begin
          m_pend  = 1'b1;
          m_paddr = b_tgt;
        end else begin
          m_lock = 1'b0;
        end
      end else begin
        if (!e.stall[3] && !m_pend) m_lock = 1'b0;
        if (m_pend && !e.stall[0])  m_pend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic i_if, i_id, i_ex, i_mem, flag, input logic [AW-1:0] tgt);
    req_if = i_if; req_id = i_id; req_ex = i_ex; req_mem = i_mem; b_flag = flag; b_tgt = tgt;
  endtask

  initial begin
    int red0, fl0;
    model_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, '0);
    repeat (2) cycle();
    rst = 1'b1;

    // idle
    repeat (3) cycle();

    // stall priority
    set_in(0, 1, 0, 1, 0, '0); cycle();
    set_in(0, 1, 0, 0, 0, '0); cycle();
    set_in(0, 0, 0, 0, 0, '0); cycle();
    set_in(1, 0, 0, 0, 0, '0); cycle();
    set_in(0, 0, 1, 0, 0, '0); cycle();
    set_in(0, 0, 0, 0, 0, '0); cycle();

    // unstalled branch: redirect same cycle
    red0 = n_red; fl0 = n_flush;
    set_in(0, 0, 0, 0, 1, 32'h100); cycle();
    set_in(0, 0, 0, 0, 0, 32'h0);   cycle();
    chk("br_nostall_redirects", 64'(n_red - red0), 64'd1);
    chk("br_nostall_flushes", 64'(n_flush - fl0), 64'd1);

    // branch held under mem stall: one flush, deferred redirect
    red0 = n_red; fl0 = n_flush;
    set_in(0, 0, 0, 1, 1, 32'h200);
    repeat (3) cycle();
    chk("pend_after_mem", 64'(rpend), 64'd1);
    set_in(0, 0, 0, 0, 1, 32'h200); cycle();
    set_in(0, 0, 0, 0, 0, 32'h0);   repeat (2) cycle();
    chk("mem_redirects", 64'(n_red - red0), 64'd1);
    chk("mem_flushes", 64'(n_flush - fl0), 64'd1);

    // branch held under ex stall
    red0 = n_red; fl0 = n_flush;
    set_in(0, 0, 1, 0, 1, 32'h280); repeat (2) cycle();
    set_in(0, 0, 0, 0, 1, 32'h280); cycle();
    set_in(0, 0, 0, 0, 0, 32'h0);   repeat (2) cycle();
    chk("ex_redirects", 64'(n_red - red0), 64'd1);
    chk("ex_flushes", 64'(n_flush - fl0), 64'd1);

    // reset during PEND discards the redirect
    red0 = n_red;
    set_in(0, 0, 0, 1, 1, 32'h300); cycle();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_pend_immediate", 64'(rpend), 64'd0);
    chk("rst_stall_cycles", 64'(scyc), 64'd0);
    chk("rst_flush_count", 64'(fcnt), 64'd0);
    set_in(0, 0, 0, 0, 0, 32'h0); repeat (2) cycle();
    rst = 1'b1;
    repeat (3) cycle();
    chk("rst_no_redirect", 64'(n_red - red0), 64'd0);

    // random traffic; a taken branch stays put while EX is frozen
    for (int i = 0; i < 400; i++) begin
      logic hold;
      hold = b_flag && (req_ex || req_mem);
      req_if  = ($urandom_range(0, 5) == 0);
      req_id  = ($urandom_range(0, 5) == 0);
      req_ex  = ($urandom_range(0, 7) == 0);
      req_mem = ($urandom_range(0, 7) == 0);
      if (!hold) begin
        b_flag = ($urandom_range(0, 3) == 0);
        b_tgt  = $urandom;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
